// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the time-shared "111" detector scheduler.
`timescale 1ns/1ps
package seq_det_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } core_state_e;

endpackage

// File: rtl/seq_det_sched_if.sv
// Requester-side bus of seq_det_sched: requests/words in, grant and result out.
`timescale 1ns/1ps
interface seq_det_sched_if import seq_det_pkg::*; #(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNTW  = $clog2(WIDTH + 1),
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic [CNTW-1:0]       hit_cnt;

  modport master (output req, data, input gnt, busy, done, done_id, hit_cnt);
  modport slave  (input req, data, output gnt, busy, done, done_id, hit_cnt);
endinterface

// File: rtl/seq_det_core.sv
// Serial "111" detector with registered hit; SEQDET_OVERLAP_EN selects overlapping detection.
`timescale 1ns/1ps
module seq_det_core import seq_det_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic bit_vld,
  input  logic bit_in,
  output logic hit
);
  core_state_e state_r, state_s;
  logic        hit_r, hit_s;

  // Next state and hit; clr wins over a valid bit
  always_comb begin
    state_s = state_r;
    hit_s   = 1'b0;
    if (clr) begin
      state_s = S0;
    end else if (bit_vld) begin
      if (!bit_in) begin
        state_s = S0;
      end else begin
        case (state_r)
          S0: state_s = S1;
          S1: state_s = S2;
          S2: begin
            hit_s = 1'b1;
`ifdef SEQDET_OVERLAP_EN
            state_s = S2;
`else
            state_s = S0;
`endif
          end
          default: state_s = S0;
        endcase
      end
    end else begin
      state_s = state_r;
    end
  end

  // State and hit registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S0;
      hit_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      hit_r   <= hit_s;
    end
  end

  assign hit = hit_r;
endmodule

// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one seq_det_core among NREQ requesters.
// Build option: SEQDET_OVERLAP_EN (overlapping detection inside the core).
`timescale 1ns/1ps
module seq_det_sched import seq_det_pkg::*; #(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic           clk,
  input  logic           rst,
  seq_det_sched_if.slave bus
);
  localparam int CNTW = $clog2(WIDTH + 1);
  localparam int IDW  = $clog2(NREQ);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] BIT_LAST = CNTW'(WIDTH - 1);
  localparam logic [NREQ-1:0] OH_ONE   = NREQ'(1);

  sched_state_e     state_r, state_s;
  logic [IDW-1:0]   last_r, id_r, done_id_r, pick_s, cand_s;
  logic             found_s, grant_s, gnt_en_s, bit_vld_s, finish_s;
  logic             core_hit_s, done_r;
  logic [WIDTH-1:0] shreg_r, word_s;
  logic [WIDTH-1:0] words_s [NREQ];
  logic [CNTW-1:0]  bit_idx_r, hits_r, hit_cnt_r;

  for (genvar g = 0; g < NREQ; g++) begin : g_word
    assign words_s[g] = bus.data[g*WIDTH +: WIDTH];
  end

  // Round-robin pick: first set req searching upward from last+1 with wrap
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    cand_s  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = IDW'((int'(last_r) + k) % NREQ);
      if (!found_s && bus.req[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        found_s = found_s;
      end
    end
    word_s = words_s[pick_s];
  end

  // Scheduler next-state and control strobes
  always_comb begin
    state_s   = state_r;
    grant_s   = 1'b0;
    bit_vld_s = 1'b0;
    finish_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          grant_s = 1'b1;
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        bit_vld_s = 1'b1;
        if (bit_idx_r == BIT_LAST) begin
          state_s = DRAIN;
        end else begin
          state_s = SHIFT;
        end
      end
      DRAIN: begin
        finish_s = 1'b1;
        state_s  = DONE;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Scheduler state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // gnt is decoded in the grant cycle itself so the word is captured on that edge
  assign gnt_en_s = grant_s & rst;

  // Word shifter, hit counter, arbiter pointer and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_r   <= '0;
      bit_idx_r <= '0;
      hits_r    <= '0;
      id_r      <= '0;
      last_r    <= IDW'(NREQ - 1);
      done_r    <= 1'b0;
      done_id_r <= '0;
      hit_cnt_r <= '0;
    end else begin
      if (gnt_en_s) begin
        shreg_r   <= word_s;
        bit_idx_r <= '0;
        id_r      <= pick_s;
        last_r    <= pick_s;
      end else if (bit_vld_s) begin
        shreg_r   <= {shreg_r[WIDTH-2:0], 1'b0};
        bit_idx_r <= bit_idx_r + CNT_ONE;
      end
      if (gnt_en_s) begin
        hits_r <= '0;
      end else if ((bit_vld_s || finish_s) && core_hit_s) begin
        hits_r <= hits_r + CNT_ONE;
      end
      done_r <= finish_s;
      // The last bit's hit arrives in DRAIN, so fold it in directly
      if (finish_s) begin
        hit_cnt_r <= hits_r + (core_hit_s ? CNT_ONE : '0);
        done_id_r <= id_r;
      end
    end
  end

  seq_det_core u_core (
    .clk     (clk),
    .rst     (rst),
    .clr     (gnt_en_s),
    .bit_vld (bit_vld_s),
    .bit_in  (shreg_r[WIDTH-1]),
    .hit     (core_hit_s)
  );

  assign bus.gnt     = gnt_en_s ? (OH_ONE << pick_s) : '0;
  assign bus.busy    = rst & ((state_r != IDLE) | grant_s);
  assign bus.done    = done_r;
  assign bus.done_id = done_id_r;
  assign bus.hit_cnt = hit_cnt_r;
endmodule

// File: tb/tb_seq_det_sched.sv
// Directed table-driven bench for seq_det_sched (expectations follow SEQDET_OVERLAP_EN).
`timescale 1ns/1ps
module tb_seq_det_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  typedef struct {
    int         id;
    logic [7:0] word;
    int         h_ov;
    int         h_nov;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         hold_cnt = 0;
  int         hold_id = 0;
  int         g_cyc = 0;
  int         prev = 0;
  logic [7:0] words [4];
  vec_t       tbl [7];

  seq_det_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  seq_det_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int pick_exp(input int ov, input int nov);
`ifdef SEQDET_OVERLAP_EN
    return ov;
`else
    return nov;
`endif
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_word(input int id, input logic [7:0] w);
    words[2'(id)] = w;
    bus.data = {words[3], words[2], words[1], words[0]};
  endtask

  task automatic wait_gnt(input int id, input string nm);
    int t;
    t = 0;
    #1;
    while (bus.gnt == 4'b0000 && t < 30) begin
      step();
      t++;
    end
    chk(nm, int'(bus.gnt), 1 << id);
    chk("busy_at_gnt", int'(bus.busy), 1);
    chk("done_at_gnt", int'(bus.done), 0);
    g_cyc = cyc;
  endtask

  // Walks G+1..G+10 (and optionally G+11) after a grant seen in cycle G
  task automatic follow(input int id, input int exp, input bit drop, input bit idle);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1 && drop) bus.req[2'(id)] = 1'b0;
      chk("gnt_quiet", int'(bus.gnt), 0);
      chk("busy_run", int'(bus.busy), 1);
      chk("done_pulse", int'(bus.done), (k == 10) ? 1 : 0);
      if (k == 10) begin
        hold_cnt = exp;
        hold_id  = id;
      end
      chk("hit_cnt", int'(bus.hit_cnt), hold_cnt);
      chk("done_id", int'(bus.done_id), hold_id);
    end
    if (idle) begin
      step();
      chk("busy_idle", int'(bus.busy), 0);
      chk("done_idle", int'(bus.done), 0);
      chk("hit_cnt_hold", int'(bus.hit_cnt), hold_cnt);
    end
  endtask

  task automatic run_word(input int id, input logic [7:0] w, input int exp);
    set_word(id, w);
    bus.req[2'(id)] = 1'b1;
    wait_gnt(id, "tbl_gnt");
    follow(id, exp, 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    hold_cnt = 0;
    hold_id  = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{0, 8'b11101111, 3, 2};
    tbl[1] = '{0, 8'hFF,       6, 2};
    tbl[2] = '{0, 8'h00,       0, 0};
    tbl[3] = '{0, 8'b10110110, 0, 0};
    tbl[4] = '{1, 8'b01110111, 2, 2};
    tbl[5] = '{3, 8'b11111100, 4, 2};
    tbl[6] = '{2, 8'hE0,       1, 1};

    for (int i = 0; i < 4; i++) words[i] = 8'h00;
    bus.data = '0;
    bus.req  = 4'b0001;
    step();
    step();
    chk("rst_gnt", int'(bus.gnt), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_done_id", int'(bus.done_id), 0);
    chk("rst_hit_cnt", int'(bus.hit_cnt), 0);
    bus.req = 4'b0000;
    step();
    rst = 1'b1;
    step();
    chk("idle_busy", int'(bus.busy), 0);

    for (int i = 0; i < 7; i++) begin
      run_word(tbl[i].id, tbl[i].word, pick_exp(tbl[i].h_ov, tbl[i].h_nov));
    end

    // Round robin with all requesters held
    do_reset();
    for (int s = 0; s < 4; s++) set_word(s, 8'hE0);
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_gnt(g % 4, "rr_gnt");
      if (g > 0) chk("rr_space", g_cyc - prev, 11);
      prev = g_cyc;
      follow(g % 4, 1, 1'b0, 1'b0);
    end
    bus.req = 4'b0000;
    step();
    step();

    // Wrap after requester 2, then reset mid-transfer
    do_reset();
    run_word(2, 8'hE0, 1);
    bus.req = 4'b0101;
    wait_gnt(0, "wrap_gnt");
    prev = g_cyc;
    follow(0, 1, 1'b1, 1'b0);
    wait_gnt(2, "wrap_next");
    chk("wrap_space", g_cyc - prev, 11);
    for (int k = 0; k < 4; k++) step();
    rst = 1'b0;
    #1;
    chk("arst_gnt", int'(bus.gnt), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_done", int'(bus.done), 0);
    chk("arst_done_id", int'(bus.done_id), 0);
    chk("arst_hit_cnt", int'(bus.hit_cnt), 0);
    hold_cnt = 0;
    hold_id  = 0;
    set_word(2, 8'b11101111);
    step();
    step();
    rst = 1'b1;
    wait_gnt(2, "post_rst_gnt");
    follow(2, pick_exp(3, 2), 1'b1, 1'b1);

    // Requester 3 withdraws before it is served; requester 0 waits
    set_word(1, 8'hFF);
    set_word(0, 8'b01110111);
    bus.req = 4'b0010;
    wait_gnt(1, "drop_gnt1");
    prev = g_cyc;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) bus.req[1] = 1'b0;
      if (k == 3) bus.req[3] = 1'b1;
      if (k == 5) begin
        bus.req[3] = 1'b0;
        bus.req[0] = 1'b1;
      end
      chk("drop_gnt_quiet", int'(bus.gnt), 0);
      chk("drop_done", int'(bus.done), (k == 10) ? 1 : 0);
    end
    chk("drop_hit_cnt", int'(bus.hit_cnt), pick_exp(6, 2));
    chk("drop_done_id", int'(bus.done_id), 1);
    hold_cnt = pick_exp(6, 2);
    hold_id  = 1;
    wait_gnt(0, "drop_gnt0");
    chk("drop_space", g_cyc - prev, 11);
    follow(0, 2, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("noreq_busy", int'(bus.busy), 0);
      chk("noreq_gnt", int'(bus.gnt), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
